// File: rtl/data_ram.sv
// Single-port 32-bit data memory answering load/store requests from the
// memory-access stage: big-endian byte lanes, optional wait states, one-cycle ack.
module data_ram #(
  parameter int ADDR_LOG2   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken on any IDLE edge with ce_i=1 and completes
  // with a single ack_o pulse; ce_i is ignored while busy_o=1, and a request
  // still presented in the IDLE cycle after ack_o is treated as a new one.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             cnt;
  logic                   req_we;
  logic [ADDR_LOG2-1:0]   req_idx;
  logic [3:0]             req_sel;
  logic [31:0]            req_data;
  logic [31:0]            mem [0:(1<<ADDR_LOG2)-1];
  logic                   capture;
  logic                   access;
  logic                   unused_addr;

  assign capture   = (state == S_IDLE) && ce_i;
  assign access    = (state == S_WAIT) && (cnt == 4'd0);
  assign busy_o    = (state != S_IDLE);
  assign state_dbg = state;
  // Upper address bits alias and the byte offset within a word is ignored.
  assign unused_addr = ^{addr_i[31:ADDR_LOG2+2], addr_i[1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ce_i) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      ack_o  <= 1'b0;
      data_o <= 32'd0;
    end else begin
      state <= state_nxt;
      ack_o <= access;
      if (capture) begin
        cnt <= 4'(WAIT_CYCLES);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !req_we) begin
        data_o <= mem[req_idx];
      end
    end
  end

  // Request registers need no reset: they are only consulted after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      req_we   <= we_i;
      req_idx  <= addr_i[ADDR_LOG2+1:2];
      req_sel  <= sel_i;
      req_data <= data_i;
    end
  end

  // sel bit b guards data[8b+7:8b]; sel[3] is the lowest byte address.
  always_ff @(posedge clk) begin
    if (access && req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) begin
          mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: three instances (0, 3 and 2 wait states) driven by
// directed and random requests, checked each cycle against a transaction model.
module tb_data_ram;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst [ND];
  logic        ce [ND];
  logic        we [ND];
  logic [31:0] addr [ND];
  logic [3:0]  sel [ND];
  logic [31:0] din [ND];
  logic [31:0] dout [ND];
  logic        ack [ND];
  logic        busy [ND];
  logic [1:0]  st [ND];

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  function automatic int wc(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_ram #(
      .ADDR_LOG2  (10),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2))
    ) dut (
      .clk      (clk),
      .rst      (rst[g]),
      .ce_i     (ce[g]),
      .we_i     (we[g]),
      .addr_i   (addr[g]),
      .sel_i    (sel[g]),
      .data_i   (din[g]),
      .data_o   (dout[g]),
      .ack_o    (ack[g]),
      .busy_o   (busy[g]),
      .state_dbg(st[g])
    );
  end

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; ce[d] = 1'b0; we[d] = 1'b0;
      addr[d] = 32'd0; sel[d] = 4'd0; din[d] = 32'd0;
    end
  end

  // inputs as seen by the DUT at the most recent rising edge
  logic        rst_s [ND];
  logic        ce_s [ND];
  logic        we_s [ND];
  logic [31:0] addr_s [ND];
  logic [3:0]  sel_s [ND];
  logic [31:0] din_s [ND];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < ND; d++) begin
      rst_s[d] <= rst[d]; ce_s[d] <= ce[d]; we_s[d] <= we[d];
      addr_s[d] <= addr[d]; sel_s[d] <= sel[d]; din_s[d] <= din[d];
    end
  end

  // behavioural model: a captured request owns the edges
  // [cap, cap+W+2]; busy after edges cap..cap+W+1, ack after edge cap+W+1
  logic [31:0] mem_m [ND][1024];
  bit          known [ND][1024];
  bit          win [ND];
  int unsigned cap [ND];
  int unsigned next_free [ND];
  bit          m_we [ND];
  logic [31:0] m_addr [ND];
  logic [3:0]  m_sel [ND];
  logic [31:0] m_data [ND];
  logic [31:0] ll [ND];
  bit          llk [ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 1024; i++) known[d][i] = 1'b0;
    end
  end

  // compare process
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      bit eb;
      bit ea;
      int idx;
      if (rst[d] || rst_s[d]) begin
        win[d] = 1'b0; next_free[d] = 0; ll[d] = 32'd0; llk[d] = 1'b1;
      end else if (ce_s[d] && cyc >= next_free[d]) begin
        win[d] = 1'b1; cap[d] = cyc; next_free[d] = cyc + wc(d) + 3;
        m_we[d] = we_s[d]; m_addr[d] = addr_s[d]; m_sel[d] = sel_s[d]; m_data[d] = din_s[d];
      end
      eb = win[d] && cyc >= cap[d] && cyc <= cap[d] + wc(d) + 1;
      ea = win[d] && cyc == cap[d] + wc(d) + 1;
      if (ea) begin
        idx = int'(m_addr[d] % 4096) / 4;
        if (m_we[d]) begin
          for (int b = 0; b < 4; b++) begin
            if (m_sel[d][b]) mem_m[d][idx][8*b +: 8] = m_data[d][8*b +: 8];
          end
          if (m_sel[d] == 4'hF) known[d][idx] = 1'b1;
        end else begin
          ll[d] = mem_m[d][idx]; llk[d] = known[d][idx];
        end
      end
      tests++;
      if (ack[d] !== ea) begin
        fails++;
        $display("FAIL ack dut%0d cyc %0d: got %b expected %b", d, cyc, ack[d], ea);
      end
      tests++;
      if (busy[d] !== eb) begin
        fails++;
        $display("FAIL busy dut%0d cyc %0d: got %b expected %b", d, cyc, busy[d], eb);
      end
      if (llk[d]) begin
        tests++;
        if (dout[d] !== ll[d]) begin
          fails++;
          $display("FAIL data_o dut%0d cyc %0d: got %h expected %h", d, cyc, dout[d], ll[d]);
        end
      end
    end
  end

  // driver tasks and literal checks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ce[d] = 1'b0;
    end
  endtask

  // Present a request in the current IDLE cycle; returns after the ack cycle
  // with ce_i still in whatever state the mode left it.
  task automatic req(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] dt, input bit drop, output logic [31:0] rd,
                     output int lat, output int bn, output int ack_at);
    int unsigned issue;
    bit got;
    @(posedge clk); #1;
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = dt;
    issue = cyc; bn = 0; got = 1'b0; rd = 32'd0; ack_at = 0;
    if (drop) begin
      @(posedge clk); #1;
      ce[d] = 1'b0; we[d] = ~w; addr[d] = $urandom(); sel[d] = 4'($urandom()); din[d] = $urandom();
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy[d]) bn++;
      if (ack[d]) begin
        got = 1'b1; rd = dout[d]; ack_at = int'(cyc);
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout dut%0d: no ack within 40 cycles of request at cyc %0d", d, issue);
    end
    lat = ack_at - int'(issue);
  endtask

  logic [31:0] rd;
  int lat, bn, a1, a2;
  int ack_seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_o", dout[0], 32'd0);
    check("reset_ack", {31'd0, ack[0]}, 32'd0);
    check("reset_busy", {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;

    // basic store/load, zero wait states
    req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, lat, bn, a1);
    check("t1_store_latency", lat, 2);
    idle(0, 1);
    req(0, 0, 32'h10, 4'hF, 32'h0, 0, rd, lat, bn, a1);
    check("t1_load_data", rd, 32'hDEADBEEF);
    check("t1_load_latency", lat, 2);
    idle(0, 1);

    // byte lanes
    req(0, 1, 32'h20, 4'hF, 32'h11223344, 0, rd, lat, bn, a1); idle(0, 1);
    req(0, 1, 32'h20, 4'h5, 32'hAABBCCDD, 0, rd, lat, bn, a1); idle(0, 1);
    req(0, 0, 32'h20, 4'h0, 32'h0, 0, rd, lat, bn, a1); idle(0, 1);
    check("t2_lanes", rd, 32'h11BB33DD);
    req(0, 1, 32'h20, 4'h0, 32'h55555555, 0, rd, lat, bn, a1); idle(0, 1);
    check("t2_sel0_latency", lat, 2);
    req(0, 0, 32'h20, 4'hF, 32'h0, 0, rd, lat, bn, a1); idle(0, 1);
    check("t2_sel0_unchanged", rd, 32'h11BB33DD);

    // aliasing and ignored byte offset
    req(0, 1, 32'h1004, 4'hF, 32'hCAFEF00D, 0, rd, lat, bn, a1); idle(0, 1);
    req(0, 0, 32'h4, 4'hF, 32'h0, 0, rd, lat, bn, a1); idle(0, 1);
    check("t4_alias", rd, 32'hCAFEF00D);
    req(0, 0, 32'h7, 4'hF, 32'h0, 0, rd, lat, bn, a1); idle(0, 1);
    check("t4_low_bits", rd, 32'hCAFEF00D);

    // back-to-back with ce held, zero and three wait states
    req(0, 1, 32'h30, 4'hF, 32'hA5A5A5A5, 0, rd, lat, bn, a1);
    req(0, 0, 32'h30, 4'hF, 32'h0, 0, rd, lat, bn, a2);
    idle(0, 2);
    check("t5_spacing_w0", a2 - a1, 3);
    check("t5_data_w0", rd, 32'hA5A5A5A5);
    req(1, 1, 32'h50, 4'hF, 32'h0F0F0F0F, 0, rd, lat, bn, a1);
    req(1, 0, 32'h50, 4'hF, 32'h0, 0, rd, lat, bn, a2);
    idle(1, 2);
    check("t5_spacing_w3", a2 - a1, 6);
    check("t5_data_w3", rd, 32'h0F0F0F0F);

    // three wait states, ce dropped after capture
    req(1, 0, 32'h50, 4'hF, 32'h0, 1, rd, lat, bn, a1); idle(1, 1);
    check("t3_latency", lat, 5);
    check("t3_busy_cycles", bn, 5);
    check("t3_data", rd, 32'h0F0F0F0F);

    // reset in the middle of a store with two wait states
    req(2, 1, 32'h40, 4'hF, 32'h0, 0, rd, lat, bn, a1); idle(2, 1);
    @(posedge clk); #1;
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; sel[2] = 4'hF; din[2] = 32'h12345678;
    @(posedge clk); #1;
    ce[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(negedge clk);
    check("t6_state_idle", {30'd0, st[2]}, 32'd0);
    check("t6_busy", {31'd0, busy[2]}, 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    ack_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[2]) ack_seen++;
    end
    check("t6_no_ack", ack_seen, 0);
    req(2, 0, 32'h40, 4'hF, 32'h0, 0, rd, lat, bn, a1); idle(2, 1);
    check("t6_store_dropped", rd, 32'h0);

    // random traffic, each instance in turn
    for (int d = 0; d < ND; d++) begin
      for (int s = 0; s < 8; s++) begin
        req(d, 1, 32'((16*s + 5) * 4), 4'hF, $urandom(), 0, rd, lat, bn, a1);
        idle(d, 1);
      end
      for (int n = 0; n < 40; n++) begin
        logic [31:0] a;
        a = ($urandom() & 32'hFFFF_F000) | 32'(((16 * $urandom_range(0, 7)) + 5) * 4)
            | 32'($urandom_range(0, 3));
        req(d, 1'($urandom_range(0, 1)), a, 4'($urandom()), $urandom(),
            1'($urandom_range(0, 1)), rd, lat, bn, a1);
        if ($urandom_range(0, 2) != 0) idle(d, $urandom_range(1, 3));
      end
      idle(d, 2);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
